esp32_osd_writer: RTL and testbench
===================================

ESP32_OSD_WRITER -- requirements
Module: esp32_osd_writer

Interface
REQ-001 SHALL have port clk_sys  in  1  system clock (50 MHz); the only clock.
REQ-002 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports host_req in 1, host_addr in 12, host_data in 8: random-access byte write request.
REQ-004 SHALL have port host_ack  out  1  combinational; high in the cycle a host write is accepted.
REQ-005 SHALL have ports str_valid in 1, str_data in 8 and str_ready out 1 (combinational): cursor-stream write handshake.
REQ-006 SHALL have ports cur_load in 1, cur_addr in 12 to set the stream cursor; cursor out 12 gives the current cursor.
REQ-007 SHALL have ports fill_start in 1, fill_base in 12, fill_len in 13 and fill_data in 8: block-fill command.
REQ-008 SHALL have ports fill_busy out 1 and fill_done out 1 (a one-cycle pulse).
REQ-009 SHALL have ports wr_addr out 12, wr_data out 8 and wr_en out 1, all registered, driving the OSD buffer write port.

Function
REQ-010 SHALL have states IDLE and FILL (plus INIT, only under the macro in REQ-025).
REQ-011 SHALL issue at most one buffer write per cycle; wr_en/wr_addr/wr_data SHALL appear exactly 1 cycle after acceptance.
REQ-012 SHALL accept fill_start only in IDLE; an accepted fill_start SHALL win over host and stream requests in the same cycle.
REQ-013 SHALL ignore fill_start outside IDLE.
REQ-014 In IDLE, when host_req and str_valid are both pending, SHALL grant round-robin, giving the grant to the requester not granted last.
REQ-015 After reset, the last-grant pointer SHALL be "stream", so host wins the first tie.
REQ-016 A sole pending requester SHALL be granted immediately; idle cycles SHALL NOT change the last-grant pointer.
REQ-017 When cur_load is high, SHALL load cursor from cur_addr and force str_ready low that cycle; host may still be granted.
REQ-018 Each accepted stream byte SHALL be written at the cursor, after which cursor increments modulo 4096 (0xFFF wraps to 0x000).
REQ-019 FILL SHALL write fill_data to (fill_base+i) mod 4096 for i = 0..fill_len-1, one byte per cycle, with no gaps.
REQ-020 Fill SHALL treat fill_len > 4096 as 4096.
REQ-021 A fill with fill_len = 0 SHALL perform no writes, pulse fill_done 1 cycle after acceptance, and stay in IDLE.
REQ-022 fill_busy SHALL be high from the cycle after acceptance through the last write cycle; fill_done SHALL pulse in the cycle after the last wr_en of the fill.
REQ-023 While fill_busy is high, host_ack and str_ready SHALL be 0, and pending requests SHALL hold.
REQ-024 Fill parameters SHALL be latched at acceptance; later input changes SHALL NOT affect an ongoing fill.

Configuration
REQ-025 With macro ESP32_OSD_WRITER_CLEAR_ON_RESET_EN defined, the block SHALL enter INIT on reset release and fill 0x000-0xFFF with 0x20.
REQ-026 INIT SHALL run for 4096 cycles with fill_busy high and fill_done not pulsed, then enter IDLE; without the macro, the block SHALL enter IDLE directly and contain no INIT state.

Reset
REQ-027 On rst_n low, SHALL asynchronously clear all of: wr_en, wr_addr, wr_data, cursor, fill_busy, fill_done and the fill counter.
REQ-028 On rst_n low, the state SHALL go to IDLE (or INIT with the macro) and the last-grant pointer SHALL be set to "stream".
REQ-029 Reset asserted mid-fill SHALL abort the fill, with no further writes and no fill_done.

Verification
REQ-030 Host write addr 0x123 data 0x41 -> host_ack in the same cycle; next cycle wr_en=1, wr_addr=0x123, wr_data=0x41.
REQ-031 cur_load 0xFFE, then stream 0x48,0x49,0x4A -> writes at 0xFFE,0xFFF,0x000; cursor=0x001.
REQ-032 host_req and str_valid held 4 cycles after reset -> grants host, stream, host, stream.
REQ-033 fill base 0xFFC, len 6, data 0x20, while host_req high -> writes 0xFFC..0xFFF,0x000,0x001; host_ack=0 during the fill; fill_done then host_ack on the following cycles.
REQ-034 fill_len 0 -> no wr_en; fill_done 1 cycle later; rst_n pulsed low mid 100-byte fill -> wr_en=0 immediately, no fill_done.
REQ-035 With ESP32_OSD_WRITER_CLEAR_ON_RESET_EN: exactly 4096 writes of 0x20 after reset, then host_ack becomes possible.

Source files
------------

// File: rtl/esp32_osd_writer.sv
// Purpose: arbitrates host random-access writes, cursor-stream writes and block fills onto one OSD buffer write port; optional power-on clear under ESP32_OSD_WRITER_CLEAR_ON_RESET_EN.
// Latency: every accepted byte appears on wr_en/wr_addr/wr_data exactly one cycle after acceptance; fills write one byte per cycle with no gaps.
// Backpressure: host_ack/str_ready are low while a fill or the power-on clear owns the port; unacked host/stream requests must hold.
module esp32_osd_writer (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        host_req,
  input  logic [11:0] host_addr,
  input  logic [7:0]  host_data,
  output logic        host_ack,
  input  logic        str_valid,
  input  logic [7:0]  str_data,
  output logic        str_ready,
  input  logic        cur_load,
  input  logic [11:0] cur_addr,
  output logic [11:0] cursor,
  input  logic        fill_start,
  input  logic [11:0] fill_base,
  input  logic [12:0] fill_len,
  input  logic [7:0]  fill_data,
  output logic        fill_busy,
  output logic        fill_done,
  output logic [11:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        wr_en
);

`ifdef ESP32_OSD_WRITER_CLEAR_ON_RESET_EN
  typedef enum logic [1:0] {IDLE, FILL, INIT} state_t;
  localparam state_t RESET_STATE = INIT;
`else
  typedef enum logic [0:0] {IDLE, FILL} state_t;
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t      state, state_d;
  logic        last_str, last_str_d;   // 1 = stream was granted most recently
  logic [12:0] fill_cnt, cnt_d;        // FILL: writes still to issue; INIT: writes issued
  logic [11:0] fill_addr, addr_d;
  logic [7:0]  fill_dat, dat_d;
  logic        issue, issue_fill, done_d;
  logic [11:0] issue_addr;
  logic [7:0]  issue_data;
  logic [12:0] len_clamped;
  logic        str_pend, grant_host, grant_str;

  assign len_clamped = (fill_len > 13'd4096) ? 13'd4096 : fill_len;
  // A cursor load steals the stream's slot for this cycle only.
  assign str_pend    = str_valid & ~cur_load;
  assign grant_host  = host_req & (~str_pend | last_str);
  assign grant_str   = str_pend & ~grant_host;

  // Next-state, arbitration and write-issue selection.
  always_comb begin
    state_d    = state;
    last_str_d = last_str;
    cnt_d      = fill_cnt;
    addr_d     = fill_addr;
    dat_d      = fill_dat;
    issue      = 1'b0;
    issue_fill = 1'b0;
    issue_addr = '0;
    issue_data = '0;
    done_d     = 1'b0;
    host_ack   = 1'b0;
    str_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (fill_start) begin
          if (len_clamped == 13'd0) begin
            done_d = 1'b1;
          end else begin
            issue      = 1'b1;
            issue_fill = 1'b1;
            issue_addr = fill_base;
            issue_data = fill_data;
            addr_d     = fill_base + 12'd1;
            dat_d      = fill_data;
            cnt_d      = len_clamped - 13'd1;
            state_d    = FILL;
          end
        end else if (grant_host) begin
          host_ack   = 1'b1;
          issue      = 1'b1;
          issue_addr = host_addr;
          issue_data = host_data;
          last_str_d = 1'b0;
        end else if (grant_str) begin
          str_ready  = 1'b1;
          issue      = 1'b1;
          issue_addr = cursor;
          issue_data = str_data;
          last_str_d = 1'b1;
        end
      end
      FILL: begin
        if (fill_cnt != 13'd0) begin
          issue      = 1'b1;
          issue_fill = 1'b1;
          issue_addr = fill_addr;
          issue_data = fill_dat;
          addr_d     = fill_addr + 12'd1;
          cnt_d      = fill_cnt - 13'd1;
        end else begin
          // Last fill byte is on the port now; done lands the cycle after it.
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
`ifdef ESP32_OSD_WRITER_CLEAR_ON_RESET_EN
      INIT: begin
        if (fill_cnt != 13'd4096) begin
          issue      = 1'b1;
          issue_fill = 1'b1;
          issue_addr = fill_cnt[11:0];
          issue_data = 8'h20;
          cnt_d      = fill_cnt + 13'd1;
        end else begin
          // Power-on clear finishes silently: no fill_done pulse.
          cnt_d   = 13'd0;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Control state, arbitration pointer and latched fill parameters.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RESET_STATE;
      last_str  <= 1'b1;
      fill_cnt  <= '0;
      fill_addr <= '0;
      fill_dat  <= '0;
    end else begin
      state     <= state_d;
      last_str  <= last_str_d;
      fill_cnt  <= cnt_d;
      fill_addr <= addr_d;
      fill_dat  <= dat_d;
    end
  end

  // Registered buffer write port plus fill status flags.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      wr_en     <= issue;
      fill_busy <= issue_fill;
      fill_done <= done_d;
      if (issue) begin
        wr_addr <= issue_addr;
        wr_data <= issue_data;
      end
    end
  end

  // Stream cursor: explicit load wins, otherwise advance on each accepted byte.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cursor <= '0;
    end else if (cur_load) begin
      cursor <= cur_addr;
    end else if (str_ready) begin
      cursor <= cursor + 12'd1;
    end
  end

endmodule

// File: tb/tb_esp32_osd_writer.sv
// Purpose: self-checking bench for esp32_osd_writer: directed scenarios then randomized host/stream traffic against a reference model.
// Latency: inputs driven 1ns after the rising edge, all outputs sampled on the falling edge.
// Backpressure: the model decides which requester is accepted each cycle and which write must appear next cycle.
module tb_esp32_osd_writer;
  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        host_req, host_ack, str_valid, str_ready, cur_load;
  logic [11:0] host_addr, cur_addr, cursor, fill_base, wr_addr;
  logic [7:0]  host_data, str_data, fill_data, wr_data;
  logic [12:0] fill_len;
  logic        fill_start, fill_busy, fill_done, wr_en;

  int tests = 0;
  int fails = 0;

  esp32_osd_writer dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .host_req(host_req), .host_addr(host_addr), .host_data(host_data), .host_ack(host_ack),
    .str_valid(str_valid), .str_data(str_data), .str_ready(str_ready),
    .cur_load(cur_load), .cur_addr(cur_addr), .cursor(cursor),
    .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len), .fill_data(fill_data),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en)
  );

  always #10 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle_inputs();
    host_req = 0; host_addr = 0; host_data = 0;
    str_valid = 0; str_data = 0; cur_load = 0; cur_addr = 0;
    fill_start = 0; fill_base = 0; fill_len = 0; fill_data = 0;
  endtask

  // Reference model state for the random phase
  bit          m_last_str;
  logic [11:0] m_cursor;
  bit          exp_we;
  logic [11:0] exp_wa;
  logic [7:0]  exp_wd;

  initial begin
    logic [11:0] ea;
    int n_wr, n_done, n_bad, winner;
    rst_n = 1'b0;
    idle_inputs();

    // ---- reset values
    repeat (2) @(posedge clk_sys);
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_cursor", cursor, 0);
    chk("rst_fill_busy", fill_busy, 0);
    chk("rst_fill_done", fill_done, 0);
    rst_n = 1'b1;

    // ---- round-robin tie right after reset: host, stream, host, stream
    host_req = 1; host_addr = 12'h200; host_data = 8'h11;
    str_valid = 1; str_data = 8'h22;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_sys);
      chk("rr_host_ack", host_ack, (k % 2 == 0));
      chk("rr_str_ready", str_ready, (k % 2 == 1));
      if (k > 0) chk("rr_wr_data", wr_data, ((k - 1) % 2 == 0) ? 8'h11 : 8'h22);
      step();
    end
    host_req = 0; str_valid = 0;
    @(negedge clk_sys);
    chk("rr_last_addr", wr_addr, 12'h001);
    chk("rr_cursor", cursor, 12'h002);
    step();

    // ---- single host write
    host_req = 1; host_addr = 12'h123; host_data = 8'h41;
    @(negedge clk_sys);
    chk("host_ack", host_ack, 1);
    step();
    host_req = 0;
    @(negedge clk_sys);
    chk("host_wr_en", wr_en, 1);
    chk("host_wr_addr", wr_addr, 12'h123);
    chk("host_wr_data", wr_data, 8'h41);
    step();

    // ---- cursor load then stream across the wrap
    cur_load = 1; cur_addr = 12'hFFE; str_valid = 1; str_data = 8'h48;
    @(negedge clk_sys);
    chk("load_str_ready", str_ready, 0);
    step();
    cur_load = 0;
    ea = 12'hFFE;
    for (int j = 0; j < 3; j++) begin
      str_data = 8'h48 + 8'(j);
      @(negedge clk_sys);
      chk("str_ready", str_ready, 1);
      if (j > 0) begin
        chk("str_wr_addr", wr_addr, ea);
        chk("str_wr_data", wr_data, 8'h48 + 8'(j - 1));
        ea = ea + 12'd1;
      end
      step();
    end
    str_valid = 0;
    @(negedge clk_sys);
    chk("str_wrap_addr", wr_addr, 12'h000);
    chk("str_wrap_data", wr_data, 8'h4A);
    chk("str_cursor", cursor, 12'h001);
    step();

    // ---- wrapping fill with a pending host request and stream
    host_req = 1; host_addr = 12'h055; host_data = 8'h77;
    fill_start = 1; fill_base = 12'hFFC; fill_len = 13'd6; fill_data = 8'h20;
    @(negedge clk_sys);
    chk("fill_wins_host", host_ack, 0);
    step();
    fill_start = 0; fill_base = 12'h000; fill_len = 13'd1; fill_data = 8'hFF;
    str_valid = 1; str_data = 8'h5A;
    ea = 12'hFFC;
    for (int i = 0; i < 6; i++) begin
      fill_start = (i == 2);
      @(negedge clk_sys);
      chk("fill_wr_en", wr_en, 1);
      chk("fill_wr_addr", wr_addr, ea);
      chk("fill_wr_data", wr_data, 8'h20);
      chk("fill_busy", fill_busy, 1);
      chk("fill_host_ack", host_ack, 0);
      chk("fill_str_ready", str_ready, 0);
      chk("fill_done_early", fill_done, 0);
      ea = ea + 12'd1;
      step();
    end
    fill_start = 0;
    @(negedge clk_sys);
    chk("fill_done", fill_done, 1);
    chk("fill_busy_end", fill_busy, 0);
    chk("fill_no_wr", wr_en, 0);
    chk("fill_then_host", host_ack, 1);
    step();
    host_req = 0; str_valid = 0;
    @(negedge clk_sys);
    chk("held_host_addr", wr_addr, 12'h055);
    chk("held_host_data", wr_data, 8'h77);
    step();

    // ---- zero-length fill
    fill_start = 1; fill_base = 12'h300; fill_len = 13'd0; fill_data = 8'h99;
    step();
    fill_start = 0;
    @(negedge clk_sys);
    chk("len0_done", fill_done, 1);
    chk("len0_wr_en", wr_en, 0);
    chk("len0_busy", fill_busy, 0);
    step();
    @(negedge clk_sys);
    chk("len0_done_pulse", fill_done, 0);
    step();

    // ---- oversize fill is clamped to 4096 bytes
    fill_start = 1; fill_base = 12'h100; fill_len = 13'h1FFF; fill_data = 8'hAB;
    step();
    fill_start = 0;
    n_wr = 0; n_done = 0; n_bad = 0; ea = 12'h100;
    for (int c = 0; c < 4100; c++) begin
      @(negedge clk_sys);
      if (wr_en) begin
        if (wr_addr !== ea || wr_data !== 8'hAB) n_bad++;
        ea = ea + 12'd1;
        n_wr++;
      end
      if (fill_done) n_done++;
      step();
    end
    chk("clamp_writes", n_wr, 4096);
    chk("clamp_bad_writes", n_bad, 0);
    chk("clamp_done_count", n_done, 1);

    // ---- reset in the middle of a 100-byte fill
    fill_start = 1; fill_base = 12'h000; fill_len = 13'd100; fill_data = 8'h33;
    step();
    fill_start = 0;
    repeat (10) step();
    @(negedge clk_sys);
    chk("midfill_active", wr_en, 1);
    step();
    rst_n = 0;
    #1;
    chk("abort_wr_en", wr_en, 0);
    chk("abort_busy", fill_busy, 0);
    step();
    step();
    rst_n = 1;
    n_wr = 0; n_done = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk_sys);
      if (wr_en) n_wr++;
      if (fill_done) n_done++;
      step();
    end
    chk("abort_no_writes", n_wr, 0);
    chk("abort_no_done", n_done, 0);
    chk("abort_cursor", cursor, 0);

    // ---- randomized host/stream/cursor traffic against the model
    m_last_str = 1; m_cursor = 12'h000; exp_we = 0; exp_wa = 0; exp_wd = 0;
    for (int c = 0; c < 400; c++) begin
      host_req  = 1'($urandom);
      host_addr = 12'($urandom);
      host_data = 8'($urandom);
      str_valid = 1'($urandom);
      str_data  = 8'($urandom);
      cur_load  = ($urandom_range(0, 7) == 0);
      cur_addr  = 12'($urandom);
      @(negedge clk_sys);
      // 0 none, 1 host, 2 stream
      if (host_req && str_valid && !cur_load) winner = m_last_str ? 1 : 2;
      else if (host_req) winner = 1;
      else if (str_valid && !cur_load) winner = 2;
      else winner = 0;
      chk("rnd_host_ack", host_ack, (winner == 1));
      chk("rnd_str_ready", str_ready, (winner == 2));
      chk("rnd_cursor", cursor, m_cursor);
      chk("rnd_wr_en", wr_en, exp_we);
      if (exp_we) begin
        chk("rnd_wr_addr", wr_addr, exp_wa);
        chk("rnd_wr_data", wr_data, exp_wd);
      end
      exp_we = (winner != 0);
      if (winner == 1) begin
        exp_wa = host_addr; exp_wd = host_data; m_last_str = 0;
      end else if (winner == 2) begin
        exp_wa = m_cursor; exp_wd = str_data; m_last_str = 1;
      end
      if (cur_load) m_cursor = cur_addr;
      else if (winner == 2) m_cursor = (m_cursor + 12'd1) % 4096;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
